// File: rtl/dma_sram_ctrl.sv
// Round-robin two-requester sequencer for the single-port 3072x32 DMA buffer SRAM; partial writes become read-modify-write.
// Grant is combinational in IDLE only; rvalid arrives 1 cycle after grant (write/err), 2 (read) or 3 (partial write); requests wait while busy.
module dma_sram_ctrl #(
  parameter int ADDR_W = 12,
  parameter int WORDS  = 3072,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_err,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_err,
  output logic                sram_cs,
  output logic                sram_web,
  output logic                sram_oe,
  output logic [ADDR_W-1:0]   sram_a,
  output logic [DATA_W-1:0]   sram_di,
  input  logic [DATA_W-1:0]   sram_do
);
  localparam int SW = DATA_W / 8;
  localparam logic [31:0] WORDS_U = 32'(WORDS);

  typedef enum logic [1:0] {IDLE, RD, RMW_RD, RMW_WR} state_e;

  state_e              state_q, state_d;
  logic                rr_last_q;
  logic                owner_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, merged_q, merged_d;
  logic [SW-1:0]       wstrb_q;
  logic                m0_rvalid_q, m0_rvalid_d, m0_err_q, m0_err_d;
  logic                m1_rvalid_q, m1_rvalid_d, m1_err_q, m1_err_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

  logic                idle, any_gnt, sel, req_we, oor, full, none;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [SW-1:0]       req_wstrb;
  logic                resp_fire, resp_own, resp_err, resp_rd;

  // On a tie the requester that did not win last time gets the slot.
  assign idle    = (state_q == IDLE) && !rst;
  assign m0_gnt  = idle && m0_req && (!m1_req || rr_last_q);
  assign m1_gnt  = idle && m1_req && (!m0_req || !rr_last_q);
  assign any_gnt = m0_gnt || m1_gnt;
  assign sel     = m1_gnt;

  assign req_we    = sel ? m1_we    : m0_we;
  assign req_addr  = sel ? m1_addr  : m0_addr;
  assign req_wdata = sel ? m1_wdata : m0_wdata;
  assign req_wstrb = sel ? m1_wstrb : m0_wstrb;
  assign oor       = {{(32-ADDR_W){1'b0}}, req_addr} >= WORDS_U;
  assign full      = &req_wstrb;
  assign none      = ~|req_wstrb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_gnt && !oor && !req_we)                   state_d = RD;
        else if (any_gnt && !oor && req_we && !full && !none) state_d = RMW_RD;
      end
      RD:      state_d = IDLE;
      RMW_RD:  state_d = RMW_WR;
      RMW_WR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sram_cs   = 1'b0;
    sram_web  = 1'b1;
    sram_oe   = 1'b0;
    sram_a    = addr_q;
    sram_di   = merged_q;
    resp_fire = 1'b0;
    resp_own  = owner_q;
    resp_err  = 1'b0;
    resp_rd   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_gnt && !oor && (!req_we || !none)) begin
          sram_cs  = 1'b1;
          sram_web = !(req_we && full);
          sram_a   = req_addr;
          sram_di  = req_wdata;
        end
        if (any_gnt && (oor || (req_we && (full || none)))) begin
          resp_fire = 1'b1;
          resp_own  = sel;
          resp_err  = oor;
        end
      end
      RD: begin
        sram_oe   = 1'b1;
        resp_fire = 1'b1;
        resp_rd   = 1'b1;
      end
      RMW_RD: sram_oe = 1'b1;
      RMW_WR: begin
        sram_cs   = 1'b1;
        sram_web  = 1'b0;
        resp_fire = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int b = 0; b < SW; b++)
      merged_d[8*b +: 8] = wstrb_q[b] ? wdata_q[8*b +: 8] : sram_do[8*b +: 8];
    m0_rvalid_d = resp_fire && !resp_own;
    m1_rvalid_d = resp_fire && resp_own;
    m0_err_d    = m0_rvalid_d && resp_err;
    m1_err_d    = m1_rvalid_d && resp_err;
    m0_rdata_d  = (m0_rvalid_d && resp_rd) ? sram_do : m0_rdata_q;
    m1_rdata_d  = (m1_rvalid_d && resp_rd) ? sram_do : m1_rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_q   <= 1'b1;
      owner_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      merged_q    <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_err_q    <= 1'b0;
      m1_err_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      if (any_gnt) begin
        rr_last_q <= sel;
        owner_q   <= sel;
        addr_q    <= req_addr;
        wdata_q   <= req_wdata;
        wstrb_q   <= req_wstrb;
      end
      if (state_q == RMW_RD) merged_q <= merged_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_err_q    <= m0_err_d;
      m1_err_q    <= m1_err_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_err    = m0_err_q;
  assign m1_err    = m1_err_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

  a_m0_hold: assert property (@(posedge clk) disable iff (rst) (m0_req && !m0_gnt) |=> m0_req);
  a_m1_hold: assert property (@(posedge clk) disable iff (rst) (m1_req && !m1_gnt) |=> m1_req);
endmodule

// File: tb/tb_dma_sram_ctrl.sv
// Bench for dma_sram_ctrl: transaction-level reference (memory image, arbitration, response schedule)
// checked every cycle, plus directed scenarios with hand-computed literals.
module tb_dma_sram_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [11:0] m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        sram_cs, sram_web, sram_oe;
  logic [11:0] sram_a;
  logic [31:0] sram_di;
  logic [31:0] sram_do = '0;

  int tests = 0;
  int fails = 0;
  int gcnt0 = 0, gcnt1 = 0;

  always #5 clk = ~clk;

  dma_sram_ctrl dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .sram_cs(sram_cs), .sram_web(sram_web), .sram_oe(sram_oe),
    .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do)
  );

  // Behavioural SRAM: registered read port.
  logic [31:0] smem [0:4095] = '{default: 32'h0};
  always @(posedge clk) begin
    if (sram_cs) begin
      if (!sram_web) smem[sram_a] <= sram_di;
      else           sram_do      <= smem[sram_a];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    bit          own;
    bit          err;
    bit          rd;
    logic [31:0] data;
    bit          wr;
    logic [11:0] addr;
  } resp_t;

  resp_t       rq[$];
  logic [31:0] ref_mem [0:4095] = '{default: 32'h0};
  bit          s_cs[16], s_wr[16], s_oe[16];
  logic [11:0] s_a[16];
  logic [31:0] s_di[16];
  int          cyc = 0, busy = 0, k;
  bit          rr_last = 1'b1;
  bit          g0, g1, own, e_rv0, e_rv1, e_err0, e_err1, r_we;
  logic [31:0] exp_rd0 = '0, exp_rd1 = '0, r_wd, mrg;
  logic [11:0] r_a;
  logic [3:0]  r_st;
  resp_t       nr;

  initial forever begin
    @(negedge clk);
    k = cyc % 16;
    if (rst) begin
      chk("rst_gnt0", m0_gnt, 0);     chk("rst_gnt1", m1_gnt, 0);
      chk("rst_cs", sram_cs, 0);      chk("rst_oe", sram_oe, 0);
      chk("rst_web", sram_web, 1);
      chk("rst_rv0", m0_rvalid, 0);   chk("rst_rv1", m1_rvalid, 0);
      chk("rst_rd0", m0_rdata, 0);    chk("rst_rd1", m1_rdata, 0);
      busy = 0; rr_last = 1'b1; rq.delete(); exp_rd0 = '0; exp_rd1 = '0;
      for (int i = 0; i < 16; i++) begin s_cs[i] = 0; s_wr[i] = 0; s_oe[i] = 0; end
    end else begin
      e_rv0 = 0; e_rv1 = 0; e_err0 = 0; e_err1 = 0;
      for (int i = rq.size() - 1; i >= 0; i--) begin
        if (rq[i].due == cyc) begin
          if (rq[i].own) begin e_rv1 = 1; e_err1 = rq[i].err; end
          else           begin e_rv0 = 1; e_err0 = rq[i].err; end
          if (rq[i].rd) begin
            if (rq[i].own) exp_rd1 = rq[i].data; else exp_rd0 = rq[i].data;
          end
          if (rq[i].wr) ref_mem[rq[i].addr] = rq[i].data;
          rq.delete(i);
        end
      end
      g0 = (busy == 0) && m0_req && (!m1_req || rr_last);
      g1 = (busy == 0) && m1_req && (!m0_req || !rr_last);
      if (g0 || g1) begin
        own  = g1;
        rr_last = own;
        r_we = own ? m1_we : m0_we;       r_a  = own ? m1_addr : m0_addr;
        r_wd = own ? m1_wdata : m0_wdata; r_st = own ? m1_wstrb : m0_wstrb;
        nr = '{due: cyc + 1, own: own, err: 0, rd: 0, data: 0, wr: 0, addr: r_a};
        if (r_a >= 12'd3072) begin
          nr.err = 1;
        end else if (r_we && r_st == 4'hF) begin
          s_cs[k] = 1; s_wr[k] = 1; s_a[k] = r_a; s_di[k] = r_wd;
          nr.wr = 1; nr.data = r_wd;
        end else if (!r_we) begin
          s_cs[k] = 1; s_wr[k] = 0; s_a[k] = r_a; s_oe[(cyc + 1) % 16] = 1;
          nr.due = cyc + 2; nr.rd = 1; nr.data = ref_mem[r_a]; busy = 1;
        end else if (r_st != 4'h0) begin
          for (int b = 0; b < 4; b++)
            mrg[8*b +: 8] = r_st[b] ? r_wd[8*b +: 8] : ref_mem[r_a][8*b +: 8];
          s_cs[k] = 1; s_wr[k] = 0; s_a[k] = r_a; s_oe[(cyc + 1) % 16] = 1;
          s_cs[(cyc + 2) % 16] = 1; s_wr[(cyc + 2) % 16] = 1;
          s_a[(cyc + 2) % 16] = r_a; s_di[(cyc + 2) % 16] = mrg;
          nr.due = cyc + 3; nr.wr = 1; nr.data = mrg; busy = 2;
        end
        rq.push_back(nr);
      end else if (busy > 0) begin
        busy--;
      end
      chk("gnt0", m0_gnt, g0);          chk("gnt1", m1_gnt, g1);
      chk("rvalid0", m0_rvalid, e_rv0); chk("rvalid1", m1_rvalid, e_rv1);
      if (e_rv0) chk("err0", m0_err, e_err0);
      if (e_rv1) chk("err1", m1_err, e_err1);
      chk("rdata0", m0_rdata, exp_rd0); chk("rdata1", m1_rdata, exp_rd1);
      chk("sram_cs", sram_cs, s_cs[k]); chk("sram_oe", sram_oe, s_oe[k]);
      chk("sram_web", sram_web, !(s_cs[k] && s_wr[k]));
      if (s_cs[k]) chk("sram_a", sram_a, s_a[k]);
      if (s_cs[k] && s_wr[k]) chk("sram_di", sram_di, s_di[k]);
      s_cs[k] = 0; s_wr[k] = 0; s_oe[k] = 0;
    end
    cyc++;
  end

  // ---------------- drivers ----------------
  task automatic issue(input int n, input logic we, input logic [11:0] a, input logic [31:0] wd,
                       input logic [3:0] st, output logic cs_at_gnt, output int waited);
    bit got = 0;
    waited = 0; cs_at_gnt = 1'bx;
    if (n == 0) begin m0_we = we; m0_addr = a; m0_wdata = wd; m0_wstrb = st; m0_req = 1; end
    else        begin m1_we = we; m1_addr = a; m1_wdata = wd; m1_wstrb = st; m1_req = 1; end
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if ((n == 0) ? m0_gnt : m1_gnt) begin
        got = 1; cs_at_gnt = sram_cs;
        if (n == 0) gcnt0++; else gcnt1++;
      end else waited++;
    end
    if (!got) begin tests++; fails++; $display("FAIL grant_timeout m%0d: got none expected gnt", n); end
    @(posedge clk); #1;
    if (n == 0) m0_req = 0; else m1_req = 0;
  endtask

  task automatic wait_rv(input int n, output logic [31:0] d, output logic e, output int lat);
    bit got = 0;
    lat = 0; d = 'x; e = 1'bx;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      lat++;
      if ((n == 0) ? m0_rvalid : m1_rvalid) begin
        got = 1;
        d = (n == 0) ? m0_rdata : m1_rdata;
        e = (n == 0) ? m0_err : m1_err;
      end
    end
    if (!got) begin tests++; fails++; $display("FAIL rvalid_timeout m%0d: got none expected rvalid", n); end
    @(posedge clk); #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  logic [31:0] d;
  logic        e, c;
  int          lat, w, lat1, g0s, g1s;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;

    // 1: full write then read back
    issue(0, 1, 12'h010, 32'hDEADBEEF, 4'hF, c, w);
    chk("t1_wr_cs", c, 1);
    wait_rv(0, d, e, lat);
    chk("t1_wr_lat", lat, 1); chk("t1_wr_err", e, 0);
    issue(0, 0, 12'h010, 32'h0, 4'h0, c, w);
    wait_rv(0, d, e, lat);
    chk("t1_rd_lat", lat, 2); chk("t1_rd_data", d, 32'hDEADBEEF);

    // 2: partial write (RMW) with m0 waiting behind it
    issue(1, 1, 12'h020, 32'h11223344, 4'hF, c, w);
    wait_rv(1, d, e, lat);
    issue(1, 1, 12'h020, 32'hAABBCCDD, 4'b0101, c, w);
    fork
      begin issue(0, 0, 12'h020, 32'h0, 4'h0, c, w); end
      begin wait_rv(1, d, e, lat1); end
    join
    chk("t2_gnt_wait", w, 2); chk("t2_rmw_lat", lat1, 3);
    wait_rv(0, d, e, lat);
    chk("t2_rd_data", d, 32'h11BB33DD);

    // 3: both hammer reads; grants must alternate
    g0s = gcnt0; g1s = gcnt1;
    fork
      begin for (int i = 0; i < 4; i++) issue(0, 0, 12'h010, 32'h0, 4'h0, c, w); end
      begin for (int i = 0; i < 4; i++) issue(1, 0, 12'h020, 32'h0, 4'h0, c, w); end
    join
    repeat (3) @(posedge clk); #1;
    chk("t3_gnts_m0", gcnt0 - g0s, 4); chk("t3_gnts_m1", gcnt1 - g1s, 4);
    chk("t3_rd1", m1_rdata, 32'h11BB33DD);

    // 4: out-of-range read
    issue(1, 0, 12'hC00, 32'h0, 4'h0, c, w);
    chk("t4_cs", c, 0);
    wait_rv(1, d, e, lat);
    chk("t4_lat", lat, 1); chk("t4_err", e, 1); chk("t4_rdata_hold", d, 32'h11BB33DD);

    // 5: reset during RMW_RD aborts the merge
    issue(0, 1, 12'h030, 32'h01020304, 4'hF, c, w);
    wait_rv(0, d, e, lat);
    issue(0, 1, 12'h030, 32'hFFFFFFFF, 4'b0011, c, w);
    rst = 1;
    @(negedge clk);
    chk("t5_oe", sram_oe, 0); chk("t5_rv", m0_rvalid, 0);
    @(posedge clk); #1 rst = 0;
    repeat (3) @(posedge clk); #1;
    issue(0, 0, 12'h030, 32'h0, 4'h0, c, w);
    chk("t5_gnt_wait", w, 0);
    wait_rv(0, d, e, lat);
    chk("t5_lat", lat, 2); chk("t5_data", d, 32'h01020304);

    // 6: zero-strobe write
    issue(0, 1, 12'h040, 32'h12345678, 4'h0, c, w);
    chk("t6_cs", c, 0);
    wait_rv(0, d, e, lat);
    chk("t6_lat", lat, 1); chk("t6_err", e, 0);
    issue(0, 0, 12'h040, 32'h0, 4'h0, c, w);
    wait_rv(0, d, e, lat);
    chk("t6_data", d, 32'h0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
